// File: rtl/i2s_pkg.sv
// Shared defaults and types for the I2S transmitter slice.
package i2s_pkg;

  localparam int unsigned DEF_PKT_WIDTH  = 16;
  localparam int unsigned DEF_SLOT_WIDTH = 16;
  localparam int unsigned FRAME_LEN      = 2 * DEF_SLOT_WIDTH;

  typedef logic [$clog2(FRAME_LEN)-1:0] slot_cnt_t;
  typedef logic [DEF_PKT_WIDTH-1:0]     sample_t;

  function automatic int unsigned frame_len(input int unsigned slot_width);
    return 2 * slot_width;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer.sv
// Slot counter, word-select generation and MSB-first shift register for one
// Philips I2S frame; the same sample is loaded into both channel slots.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned PKT_WIDTH  = DEF_PKT_WIDTH,
  parameter int unsigned SLOT_WIDTH = DEF_SLOT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [PKT_WIDTH-1:0] sample_i,
  output logic                 frame_end_o,
  output logic                 ws_o,
  output logic                 sd_o
);

  localparam int unsigned FLEN  = frame_len(SLOT_WIDTH);
  localparam int unsigned CNT_W = $clog2(FLEN);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0] LEFT_END  = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] WS_HI     = CNT_W'(FLEN - 2);

  logic [CNT_W-1:0]      k_q, k_d;
  logic                  ws_q, ws_d;
  logic [SLOT_WIDTH-1:0] shift_q, shift_d;
  logic [SLOT_WIDTH-1:0] word;

  // Left-justify the sample inside the slot, zero-padding the LSBs.
  assign word = SLOT_WIDTH'(sample_i) << (SLOT_WIDTH - PKT_WIDTH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    k_d     = (k_q == LAST_SLOT) ? '0 : k_q + 1'b1;
    ws_d    = (k_d >= LEFT_END) && (k_d <= WS_HI);
    shift_d = shift_q << 1;
    if (load_i || (k_q == LEFT_END)) begin
      shift_d = word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q     <= LAST_SLOT;
      ws_q    <= 1'b0;
      shift_q <= '0;
    end else begin
      k_q     <= k_d;
      ws_q    <= ws_d;
      shift_q <= shift_d;
    end
  end

  assign frame_end_o = (k_q == LAST_SLOT);
  assign ws_o        = ws_q;
  assign sd_o        = shift_q[SLOT_WIDTH-1];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter top: holding register, bypass/valid logic and status pulses.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned PKT_WIDTH  = DEF_PKT_WIDTH,
  parameter int unsigned SLOT_WIDTH = DEF_SLOT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktChanged_i,
  output logic                 ws_o,
  output logic                 sd_o,
  output logic                 pktTaken_o,
  output logic                 underrun_o,
  output logic                 overrun_o
);

  logic [PKT_WIDTH-1:0] hold_q, hold_d;
  logic [PKT_WIDTH-1:0] frame_q, frame_d;
  logic                 valid_q, valid_d;
  logic                 taken_q, taken_d;
  logic                 under_q, under_d;
  logic                 over_q, over_d;
  logic                 frame_end;

  always_comb begin
    hold_d  = pktChanged_i ? pkt_i : hold_q;
    frame_d = frame_q;
    valid_d = valid_q | pktChanged_i;
    taken_d = 1'b0;
    under_d = 1'b0;
    over_d  = pktChanged_i & valid_q;
    if (frame_end) begin
      // A strobe coinciding with the frame load bypasses the holding register.
      valid_d = 1'b0;
      over_d  = 1'b0;
      if (pktChanged_i) begin
        frame_d = pkt_i;
        taken_d = 1'b1;
      end else if (valid_q) begin
        frame_d = hold_q;
        taken_d = 1'b1;
      end else begin
        under_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        frame_d = '0;
`else
        frame_d = frame_q;
`endif
      end
    end
  end

  // NOTE: reset clears every register here, including the sample storage, so a reset aborts cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  // frame_d equals frame_q except on the load edge, so it serves both reloads.
  i2s_tx_serializer #(
    .PKT_WIDTH (PKT_WIDTH),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (frame_end),
    .sample_i   (frame_d),
    .frame_end_o(frame_end),
    .ws_o       (ws_o),
    .sd_o       (sd_o)
  );

  assign pktTaken_o = taken_q;
  assign underrun_o = under_q;
  assign overrun_o  = over_q;

endmodule
